// File: rtl/instr_exec_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_exec_sequencer_if                                          |
// | Purpose  : Control, register-read and write-back bundle of the sequencer.   |
// |            rd_instr packs {opc[67:64], op_a[63:32], op_b[31:0]}.            |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface instr_exec_sequencer_if;
  logic        start;
  logic [4:0]  start_addr;
  logic [5:0]  count;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [67:0] rd_instr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_result;
  logic        busy;
  logic        done;
  logic        err_div0;
  logic        err_illegal;

  modport master (
    output start, start_addr, count, abort, rd_instr,
    input  rd_addr, wr_en, wr_addr, wr_result, busy, done, err_div0, err_illegal
  );

  modport slave (
    input  start, start_addr, count, abort, rd_instr,
    output rd_addr, wr_en, wr_addr, wr_result, busy, done, err_div0, err_illegal
  );
endinterface
`default_nettype wire

// File: rtl/instr_exec_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : instr_exec_sequencer                                             |
// | Purpose  : Walks a range of the instruction register, executes each entry   |
// |            and writes its 64-bit signed result back.                        |
// | Options  : EXEC_DIVMOD_EN builds the iterative DIV/MOD divider.             |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module instr_exec_sequencer #(
  parameter int NUM_ENTRIES = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_exec_sequencer_if.slave  bus
);
  localparam logic [4:0] ADDR_MASK = 5'(NUM_ENTRIES - 1);

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_DIVIDE = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t       state_q;
  logic [4:0]   ptr_q;
  logic [5:0]   remain_q;
  logic [3:0]   opc_q;
  logic [31:0]  op_a_q;
  logic [31:0]  op_b_q;
  logic [4:0]   rd_addr_q;
  logic         wr_en_q;
  logic [4:0]   wr_addr_q;
  logic [63:0]  wr_result_q;
  logic         busy_q;
  logic         done_q;
  logic         err_illegal_q;

  logic [4:0]          ptr_inc_d;
  logic [32:0]         sum_d;
  logic [32:0]         diff_d;
  logic signed [63:0]  prod_d;
  logic [63:0]         result_d;
  logic                illegal_d;
  logic                is_divmod_d;

  assign ptr_inc_d   = (ptr_q + 5'd1) & ADDR_MASK;
  assign sum_d       = {op_a_q[31], op_a_q} + {op_b_q[31], op_b_q};
  assign diff_d      = {op_a_q[31], op_a_q} - {op_b_q[31], op_b_q};
  assign prod_d      = 64'($signed(op_a_q)) * 64'($signed(op_b_q));
  assign is_divmod_d = (opc_q == OPC_DIV) || (opc_q == OPC_MOD);

  // Single-cycle results; DIV/MOD yield 0 here and are only kept when the divisor is 0
  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    case (opc_q)
      OPC_ZERO:  result_d = '0;
      OPC_PASSA: result_d = {{32{op_a_q[31]}}, op_a_q};
      OPC_PASSB: result_d = {{32{op_b_q[31]}}, op_b_q};
      OPC_ADD:   result_d = {{31{sum_d[32]}}, sum_d};
      OPC_SUB:   result_d = {{31{diff_d[32]}}, diff_d};
      OPC_MULT:  result_d = prod_d;
      OPC_DIV, OPC_MOD: begin
`ifndef EXEC_DIVMOD_EN
        illegal_d = 1'b1;
`endif
      end
      default:   illegal_d = 1'b1;
    endcase
  end

`ifdef EXEC_DIVMOD_EN
  logic         err_div0_q;
  logic [31:0]  quo_q;
  logic [31:0]  rem_q;
  logic [31:0]  den_q;
  logic [4:0]   iter_q;
  logic         q_neg_q;
  logic         r_neg_q;

  logic [32:0]  shift_d;
  logic         ge_d;
  logic [31:0]  rem_next_d;
  logic [31:0]  quo_next_d;
  logic [31:0]  mag_a_d;
  logic [31:0]  mag_b_d;
  logic [63:0]  div_res_d;

  // Restoring step; when shift_d[32] is set the true difference still fits in 32 bits
  assign shift_d    = {rem_q, quo_q[31]};
  assign ge_d       = shift_d[32] | (shift_d[31:0] >= den_q);
  assign rem_next_d = shift_d[31:0] - (ge_d ? den_q : 32'd0);
  assign quo_next_d = {quo_q[30:0], ge_d};
  assign mag_a_d    = op_a_q[31] ? (32'd0 - op_a_q) : op_a_q;
  assign mag_b_d    = op_b_q[31] ? (32'd0 - op_b_q) : op_b_q;

  always_comb begin
    div_res_d = '0;
    if (opc_q == OPC_DIV)
      div_res_d = q_neg_q ? (64'd0 - {32'd0, quo_next_d}) : {32'd0, quo_next_d};
    else
      div_res_d = r_neg_q ? (64'd0 - {32'd0, rem_next_d}) : {32'd0, rem_next_d};
  end

  assign bus.err_div0 = err_div0_q;
`else
  assign bus.err_div0 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      remain_q      <= '0;
      opc_q         <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_result_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
`ifdef EXEC_DIVMOD_EN
      err_div0_q    <= 1'b0;
      quo_q         <= '0;
      rem_q         <= '0;
      den_q         <= '0;
      iter_q        <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          // DONE accepts a new start exactly like IDLE
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              ptr_q         <= bus.start_addr & ADDR_MASK;
              remain_q      <= bus.count;
              err_illegal_q <= 1'b0;
`ifdef EXEC_DIVMOD_EN
              err_div0_q    <= 1'b0;
`endif
              if (bus.count == 6'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= S_FETCH;
                rd_addr_q <= bus.start_addr & ADDR_MASK;
                busy_q    <= 1'b1;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_FETCH: state_q <= S_LATCH;
          S_LATCH: begin
            opc_q   <= bus.rd_instr[67:64];
            op_a_q  <= bus.rd_instr[63:32];
            op_b_q  <= bus.rd_instr[31:0];
            state_q <= S_EXEC;
          end
          S_EXEC: begin
`ifdef EXEC_DIVMOD_EN
            if (is_divmod_d && (op_b_q != 32'd0)) begin
              quo_q   <= mag_a_d;
              rem_q   <= '0;
              den_q   <= mag_b_d;
              iter_q  <= '0;
              q_neg_q <= op_a_q[31] ^ op_b_q[31];
              r_neg_q <= op_a_q[31];
              state_q <= S_DIVIDE;
            end else
`endif
            begin
              wr_en_q     <= 1'b1;
              wr_addr_q   <= ptr_q;
              wr_result_q <= result_d;
              if (illegal_d)
                err_illegal_q <= 1'b1;
`ifdef EXEC_DIVMOD_EN
              if (is_divmod_d)
                err_div0_q <= 1'b1;
`endif
              state_q <= S_WB;
            end
          end
`ifdef EXEC_DIVMOD_EN
          S_DIVIDE: begin
            quo_q  <= quo_next_d;
            rem_q  <= rem_next_d;
            iter_q <= iter_q + 5'd1;
            if (iter_q == 5'd31) begin
              wr_en_q     <= 1'b1;
              wr_addr_q   <= ptr_q;
              wr_result_q <= div_res_d;
              state_q     <= S_WB;
            end
          end
`endif
          S_WB: begin
            ptr_q    <= ptr_inc_d;
            remain_q <= remain_q - 6'd1;
            if (remain_q == 6'd1) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_FETCH;
              rd_addr_q <= ptr_inc_d;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_result   = wr_result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_illegal = err_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_exec_sequencer.sv
`default_nettype none
// Directed self-checking bench for instr_exec_sequencer; expectations follow
// EXEC_DIVMOD_EN so the same bench covers both builds.
module tb_instr_exec_sequencer;
`ifdef EXEC_DIVMOD_EN
  localparam bit DIVMOD = 1'b1;
`else
  localparam bit DIVMOD = 1'b0;
`endif
  localparam logic [3:0] ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3;
  localparam logic [3:0] SUB = 4'd4, MULT = 4'd5, DIV = 4'd6, MOD = 4'd7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_exec_sequencer_if bus();
  instr_exec_sequencer #(.NUM_ENTRIES(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  // Instruction register model: read data valid one cycle after the address
  logic [67:0] mem [0:31];
  always @(posedge clk) bus.rd_instr <= mem[bus.rd_addr];

  int checks = 0;
  int failures = 0;
  logic [4:0]  w_addr [0:15];
  logic [63:0] w_res  [0:15];
  int          w_cyc  [0:15];
  int          nwr, ndone, done_cyc;
  logic        div0_at_done, ill_at_done;
  logic        busy_log [0:127];
  logic [78:0] outs_log [0:127];

  function automatic logic [67:0] ins(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    return {o, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and log every cycle k = 1..max_cyc after the accepting edge
  task automatic run(input logic [4:0] sa, input logic [5:0] cnt, input int max_cyc,
                     input int abort_at, input int restart_at, input int reset_at);
    nwr = 0; ndone = 0; done_cyc = -1; div0_at_done = 1'bx; ill_at_done = 1'bx;
    for (int i = 0; i < 16; i++) begin w_addr[i] = 'x; w_res[i] = 'x; w_cyc[i] = -1; end
    bus.start_addr = sa; bus.count = cnt; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      outs_log[k] = {bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_result,
                     bus.busy, bus.done, bus.err_div0, bus.err_illegal};
      busy_log[k] = bus.busy;
      if (bus.wr_en && nwr < 16) begin
        w_addr[nwr] = bus.wr_addr; w_res[nwr] = bus.wr_result; w_cyc[nwr] = k; nwr++;
      end
      if (bus.done) begin
        ndone++; done_cyc = k; div0_at_done = bus.err_div0; ill_at_done = bus.err_illegal;
      end
      if (k == abort_at) bus.abort = 1'b1;
      if (k == restart_at) begin bus.start = 1'b1; bus.start_addr = 5'd9; bus.count = 6'd0; end
      if (k == reset_at) reset_n = 1'b0;
      tick();
      bus.abort = 1'b0; bus.start = 1'b0; reset_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [78:0] v;
    reset_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.start_addr = '0; bus.count = '0;
    tick(); tick();
    v = {bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_result, bus.busy, bus.done, bus.err_div0, bus.err_illegal};
    checks++;
    if (v !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", v); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    logic [63:0] exp_res [0:3];
    exp_res[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_res[1] = 64'hFFFF_FFFF_7FFF_FFFF;
    exp_res[2] = 64'hFFFF_FFFF_FFFF_FFEB;
    exp_res[3] = 64'd42;
    mem[0] = ins(ADD, 32'd5, 32'hFFFF_FFF7);
    mem[1] = ins(SUB, 32'h8000_0000, 32'd1);
    mem[2] = ins(MULT, 32'hFFFF_FFFD, 32'd7);
    mem[3] = ins(PASSB, 32'd0, 32'd42);
    run(5'd0, 6'd4, 24, -1, -1, -1);
    checks++;
    if (busy_log[1] !== 1'b1 || outs_log[1][78:74] !== 5'd0) begin
      failures++; $display("FAIL arith_first_fetch: busy=%b rd_addr=%0d expected busy=1 rd_addr=0", busy_log[1], outs_log[1][78:74]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w_addr[i] !== 5'(i) || w_res[i] !== exp_res[i] || w_cyc[i] != 4 * (i + 1)) begin
        failures++;
        $display("FAIL arith_write%0d: got addr=%0d res=%h cyc=%0d expected addr=%0d res=%h cyc=%0d",
                 i, w_addr[i], w_res[i], w_cyc[i], i, exp_res[i], 4 * (i + 1));
      end
    end
    checks++;
    if (nwr != 4 || ndone != 1 || done_cyc != 17) begin
      failures++; $display("FAIL arith_done: got writes=%0d dones=%0d done_cyc=%0d expected 4 1 17", nwr, ndone, done_cyc);
    end
    checks++;
    if (busy_log[16] !== 1'b1 || busy_log[17] !== 1'b0) begin
      failures++; $display("FAIL arith_busy_end: got wb=%b done=%b expected 1 0", busy_log[16], busy_log[17]);
    end
  endtask

  task automatic test_divmod_wrap();
    logic [4:0]  ea [0:2];
    logic [63:0] er [0:2];
    int          ec [0:2];
    ea[0] = 5'd30; ea[1] = 5'd31; ea[2] = 5'd0;
    er[0] = DIVMOD ? 64'h0000_0000_8000_0000 : 64'd0;
    er[1] = DIVMOD ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
    er[2] = 64'd3;
    ec[0] = DIVMOD ? 36 : 4; ec[1] = DIVMOD ? 72 : 8; ec[2] = DIVMOD ? 76 : 12;
    mem[30] = ins(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    mem[31] = ins(MOD, 32'hFFFF_FFF9, 32'd2);
    mem[0]  = ins(ADD, 32'd1, 32'd2);
    run(5'd30, 6'd3, 90, -1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_addr[i] !== ea[i] || w_res[i] !== er[i] || w_cyc[i] != ec[i]) begin
        failures++;
        $display("FAIL divmod_write%0d: got addr=%0d res=%h cyc=%0d expected addr=%0d res=%h cyc=%0d",
                 i, w_addr[i], w_res[i], w_cyc[i], ea[i], er[i], ec[i]);
      end
    end
    checks++;
    if (nwr != 3 || ndone != 1 || done_cyc != (DIVMOD ? 77 : 13)) begin
      failures++; $display("FAIL divmod_done: got writes=%0d dones=%0d done_cyc=%0d expected 3 1 %0d",
                           nwr, ndone, done_cyc, DIVMOD ? 77 : 13);
    end
    checks++;
    if (ill_at_done !== !DIVMOD) begin
      failures++; $display("FAIL divmod_illegal_flag: got %b expected %b", ill_at_done, !DIVMOD);
    end
  endtask

  task automatic test_errors();
    mem[5] = ins(DIV, 32'd10, 32'd0);
    mem[6] = ins(4'hF, 32'd1, 32'd1);
    run(5'd5, 6'd2, 20, -1, -1, -1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (w_addr[i] !== 5'(5 + i) || w_res[i] !== 64'd0 || w_cyc[i] != 4 * (i + 1)) begin
        failures++; $display("FAIL err_write%0d: got addr=%0d res=%h cyc=%0d expected addr=%0d res=0 cyc=%0d",
                             i, w_addr[i], w_res[i], w_cyc[i], 5 + i, 4 * (i + 1));
      end
    end
    checks++;
    if (done_cyc != 9 || div0_at_done !== DIVMOD || ill_at_done !== 1'b1) begin
      failures++; $display("FAIL err_flags_at_done: got done_cyc=%0d div0=%b illegal=%b expected 9 %b 1",
                           done_cyc, div0_at_done, ill_at_done, DIVMOD);
    end
  endtask

  task automatic test_count0();
    logic [4:0] prev_rd;
    prev_rd = bus.rd_addr;
    run(5'd7, 6'd0, 6, -1, -1, -1);
    checks++;
    if (done_cyc != 1 || ndone != 1 || nwr != 0) begin
      failures++; $display("FAIL count0_done: got done_cyc=%0d dones=%0d writes=%0d expected 1 1 0", done_cyc, ndone, nwr);
    end
    checks++;
    if (outs_log[1][78:74] !== prev_rd || busy_log[1] !== 1'b0) begin
      failures++; $display("FAIL count0_rdaddr: got rd_addr=%0d busy=%b expected rd_addr=%0d busy=0",
                           outs_log[1][78:74], busy_log[1], prev_rd);
    end
    checks++;
    if (outs_log[1][1:0] !== 2'b00) begin
      failures++; $display("FAIL count0_err_clear: got %b expected 00", outs_log[1][1:0]);
    end
  endtask

  task automatic test_busy_ignore();
    mem[0] = ins(PASSA, 32'd11, 32'd0);
    mem[1] = ins(PASSA, 32'd12, 32'd0);
    run(5'd0, 6'd2, 20, -1, 3, -1);
    checks++;
    if (nwr != 2 || ndone != 1 || done_cyc != 9 || w_res[1] !== 64'd12) begin
      failures++; $display("FAIL busy_start_ignored: got writes=%0d dones=%0d done_cyc=%0d res1=%h expected 2 1 9 c",
                           nwr, ndone, done_cyc, w_res[1]);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) mem[i] = ins(PASSA, 32'(i + 100), 32'd0);
    run(5'd0, 6'd8, 30, 11, -1, -1);
    checks++;
    if (nwr != 2 || ndone != 0) begin
      failures++; $display("FAIL abort_writes: got writes=%0d dones=%0d expected 2 0", nwr, ndone);
    end
    checks++;
    if (busy_log[11] !== 1'b1 || busy_log[12] !== 1'b0) begin
      failures++; $display("FAIL abort_busy: got exec=%b next=%b expected 1 0", busy_log[11], busy_log[12]);
    end
  endtask

  task automatic test_reset_mid_run();
    int ra;
    ra = DIVMOD ? 10 : 2;
    mem[3] = ins(DIV, 32'd100, 32'd7);
    run(5'd3, 6'd1, 40, -1, -1, ra);
    checks++;
    if (outs_log[ra + 1] !== '0 || nwr != 0 || ndone != 0) begin
      failures++; $display("FAIL midrun_reset: got outs=%h writes=%0d dones=%0d expected 0 0 0",
                           outs_log[ra + 1], nwr, ndone);
    end
    run(5'd3, 6'd1, 40, -1, -1, -1);
    checks++;
    if (nwr != 1 || w_addr[0] !== 5'd3 || w_res[0] !== (DIVMOD ? 64'd14 : 64'd0) ||
        w_cyc[0] != (DIVMOD ? 36 : 4) || done_cyc != (DIVMOD ? 37 : 5)) begin
      failures++; $display("FAIL rerun_after_reset: got writes=%0d addr=%0d res=%h cyc=%0d done=%0d expected 1 3 %h %0d %0d",
                           nwr, w_addr[0], w_res[0], w_cyc[0], done_cyc,
                           DIVMOD ? 64'd14 : 64'd0, DIVMOD ? 36 : 4, DIVMOD ? 37 : 5);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.start_addr = '0; bus.count = '0;
    test_reset();
    test_arith();
    test_divmod_wrap();
    test_errors();
    test_count0();
    test_busy_ignore();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
